// File: rtl/debounce_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : debounce_pkg                                               |
// | Description : Shared types and constants for the push-button debounce    |
// |               path: debounce FSM state encoding and stability-window     |
// |               defaults (silicon value and short simulation value).       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package debounce_pkg;

   // Debounce FSM states, 2-bit encoding.
   typedef enum logic [1:0] {
      IDLE_LOW  = 2'd0,
      WAIT_HIGH = 2'd1,
      IDLE_HIGH = 2'd2,
      WAIT_LOW  = 2'd3
   } state_t;

   // Stability window in clock cycles: 500000 for silicon, 4 for simulation.
   localparam int unsigned DEFAULT_STABLE_CYCLES = 32'd500000;
   localparam int unsigned SIM_STABLE_CYCLES     = 32'd4;

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sync_2ff                                                   |
// | Description : Generic two-flop synchronizer for asynchronous inputs.     |
// |               Both stages clear on reset.                                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk      in   1      sampling clock, rising edge                       |
// |   reset_n  in   1      asynchronous active-low reset                     |
// |   d_i      in   WIDTH  asynchronous input                                |
// |   q_o      out  WIDTH  synchronized output (two clocks of latency)       |
// +--------------------------------------------------------------------------+
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] s1_q;
   logic [WIDTH-1:0] s2_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/debounce_pulse.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : debounce_pulse                                             |
// | Description : Turns a raw bouncing push-button level into a debounced    |
// |               level and a single-cycle pulse on each accepted press,     |
// |               suitable for driving a toggle stage's T input.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk        in   1  system clock, rising edge                           |
// |   reset_n    in   1  asynchronous active-low reset                       |
// |   btn_in     in   1  raw asynchronous button level (1 = pressed)         |
// |   db_level   out  1  debounced button level (registered)                 |
// |   pulse_out  out  1  one-cycle pulse on an accepted press (registered)   |
// | Build option                                                             |
// |   RELEASE_PULSE_EN  when defined, pulse_out also fires on an accepted    |
// |                     release. Port list is the same in both builds.       |
// +--------------------------------------------------------------------------+
module debounce_pulse #(
   parameter int unsigned STABLE_CYCLES = debounce_pkg::DEFAULT_STABLE_CYCLES
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_in,
   output logic db_level,
   output logic pulse_out
);

   import debounce_pkg::*;

   localparam int                   CNT_WIDTH = $clog2(STABLE_CYCLES);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(STABLE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

   logic                 btn_s;
   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 db_level_q, db_level_d;
   logic                 pulse_q, pulse_d;

   sync_2ff #(
      .WIDTH (1)
   ) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d_i     (btn_in),
      .q_o     (btn_s)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE_LOW;
         cnt_q      <= '0;
         db_level_q <= 1'b0;
         pulse_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         db_level_q <= db_level_d;
         pulse_q    <= pulse_d;
      end
   end

   // The counter only runs in the WAIT states and is cleared on every state
   // change, so it never exceeds CNT_MAX. Any sample disagreeing with the
   // candidate level sends the FSM back and restarts qualification.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      db_level_d = db_level_q;
      pulse_d    = 1'b0;
      case (state_q)
         IDLE_LOW: begin
            if (btn_s) begin
               state_d = WAIT_HIGH;
               cnt_d   = '0;
            end
         end
         WAIT_HIGH: begin
            if (!btn_s) begin
               state_d = IDLE_LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d    = IDLE_HIGH;
               cnt_d      = '0;
               db_level_d = 1'b1;
               pulse_d    = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         IDLE_HIGH: begin
            if (!btn_s) begin
               state_d = WAIT_LOW;
               cnt_d   = '0;
            end
         end
         WAIT_LOW: begin
            if (btn_s) begin
               state_d = IDLE_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d    = IDLE_LOW;
               cnt_d      = '0;
               db_level_d = 1'b0;
`ifdef RELEASE_PULSE_EN
               pulse_d    = 1'b1;
`else
               pulse_d    = 1'b0;
`endif
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE_LOW;
            cnt_d   = '0;
         end
      endcase
   end

   assign db_level  = db_level_q;
   assign pulse_out = pulse_q;

endmodule : debounce_pulse
`default_nettype wire
